mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/wait_counter.sv | 37 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter
// and the peripheral sequencers built on its wait counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter with a zero flag; holds at zero
// rather than wrapping so an idle counter stays quiet.
import mem_arb_pkg::*;

module wait_counter #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer giving the core FSM or the
// debug/loader port access to the unified memory.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [WIDTH-1:0] core_adr,
  input  logic [WIDTH-1:0] core_wd,
  output logic             core_ready,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [WIDTH-1:0] dbg_adr,
  input  logic [WIDTH-1:0] dbg_wd,
  output logic             dbg_ready,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             busy,
  output logic             gnt_id
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  arb_state_e       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] adr_q, adr_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pick;
  logic             cnt_load, cnt_en, cnt_zero;

  wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    mem_we_d = 1'b0;
    adr_d    = adr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    // On a tie the side that did not win last time goes next
    pick = (core_req & dbg_req) ? ~gnt_q : dbg_req;
    unique case (state_q)
      ARB_IDLE: begin
        if (core_req | dbg_req) begin
          state_d  = ARB_ACCESS;
          gnt_d    = pick;
          cnt_load = 1'b1;
          if (pick == REQ_DBG) begin
            adr_d = dbg_adr;
            wd_d  = dbg_wd;
            we_d  = dbg_we;
          end else begin
            adr_d = core_adr;
            wd_d  = core_wd;
            we_d  = core_we;
          end
          mem_we_d = we_d;
        end
      end
      ARB_ACCESS: begin
        if (cnt_zero) begin
          state_d = ARB_DONE;
          if (!we_q) begin
            rdata_d = mem_rd;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= REQ_DBG;
      we_q     <= 1'b0;
      mem_we_q <= 1'b0;
      adr_q    <= '0;
      wd_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      mem_we_q <= mem_we_d;
      adr_q    <= adr_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
    end
  end

  assign core_ready = (state_q == ARB_DONE) && (gnt_q == REQ_CORE);
  assign dbg_ready  = (state_q == ARB_DONE) && (gnt_q == REQ_DBG);
  assign busy       = (state_q != ARB_IDLE);
  assign gnt_id     = gnt_q;
  assign mem_we     = mem_we_q;
  assign mem_adr    = adr_q;
  assign mem_wd     = wd_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LATENCY=1 and LATENCY=3 instances,
// directed vectors/sequences plus a transaction-level model.
module tb_mem_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, creq, cwe, dreq, dwe;
  logic [1:0][31:0] cadr, cwd, dadr, dwd;
  logic [1:0]       cready, dready, mwe, busy, gnt;
  logic [1:0][31:0] rdata, madr, mwd, mrd;

  mem_arbiter #(.WIDTH(32), .LATENCY(LAT0)) u_dut1 (
    .clk(clk), .reset(rst[0]),
    .core_req(creq[0]), .core_we(cwe[0]),
    .core_adr(cadr[0]), .core_wd(cwd[0]),
    .core_ready(cready[0]),
    .dbg_req(dreq[0]), .dbg_we(dwe[0]),
    .dbg_adr(dadr[0]), .dbg_wd(dwd[0]),
    .dbg_ready(dready[0]), .rdata(rdata[0]),
    .mem_we(mwe[0]), .mem_adr(madr[0]),
    .mem_wd(mwd[0]), .mem_rd(mrd[0]),
    .busy(busy[0]), .gnt_id(gnt[0])
  );

  mem_arbiter #(.WIDTH(32), .LATENCY(LAT1)) u_dut3 (
    .clk(clk), .reset(rst[1]),
    .core_req(creq[1]), .core_we(cwe[1]),
    .core_adr(cadr[1]), .core_wd(cwd[1]),
    .core_ready(cready[1]),
    .dbg_req(dreq[1]), .dbg_we(dwe[1]),
    .dbg_adr(dadr[1]), .dbg_wd(dwd[1]),
    .dbg_ready(dready[1]), .rdata(rdata[1]),
    .mem_we(mwe[1]), .mem_adr(madr[1]),
    .mem_wd(mwd[1]), .mem_rd(mrd[1]),
    .busy(busy[1]), .gnt_id(gnt[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] init_word(input int d, input int i);
    if (d == 0 && i == 4) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 + 32'(d * 256 + i);
  endfunction

  // 16-word memories, word index = adr[5:2]
  logic [31:0] pmem [2][16];
  bit mem_init = 1'b1;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_init) begin
        for (int i = 0; i < 16; i++) pmem[d][i] <= init_word(d, i);
      end else if (mwe[d]) begin
        pmem[d][madr[d][5:2]] <= mwd[d];
      end
    end
  end

  assign mrd[0] = pmem[0][madr[0][5:2]];
  assign mrd[1] = pmem[1][madr[1][5:2]];

  // Transaction-level reference: arbiter is free every LAT+2 cycles
  int          cyc = 0;
  int          free_at [2];
  int          grant_at [2];
  int          done_at [2];
  bit          last [2];
  bit          act_we [2];
  logic [31:0] act_adr [2];
  logic [31:0] act_wd [2];
  logic [31:0] exp_rd [2];
  logic [31:0] ref_mem [2][16];
  bit          sync_ref = 1'b0;
  bit          model_en = 1'b0;

  always @(posedge clk) begin
    int k;
    bit w;
    logic [31:0] a, wd;
    bit we;
    k = cyc + 1;
    cyc <= k;
    for (int d = 0; d < 2; d++) begin
      if (sync_ref) begin
        for (int i = 0; i < 16; i++) ref_mem[d][i] <= pmem[d][i];
      end
      if (rst[d]) begin
        free_at[d]  <= 0;
        grant_at[d] <= -10;
        done_at[d]  <= -10;
        last[d]     <= 1'b1;
      end else if (k >= free_at[d] && (creq[d] || dreq[d])) begin
        w  = (creq[d] && dreq[d]) ? !last[d] : dreq[d];
        a  = w ? dadr[d] : cadr[d];
        wd = w ? dwd[d] : cwd[d];
        we = w ? dwe[d] : cwe[d];
        last[d]     <= w;
        grant_at[d] <= k;
        done_at[d]  <= k + lat(d);
        free_at[d]  <= k + lat(d) + 2;
        act_adr[d]  <= a;
        act_wd[d]   <= wd;
        act_we[d]   <= we;
        if (we) ref_mem[d][a[5:2]] <= wd;
        else exp_rd[d] <= ref_mem[d][a[5:2]];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      logic e_busy, e_cr, e_dr, e_we, ok;
      e_busy = (cyc >= grant_at[d]) && (cyc <= done_at[d]);
      e_cr = (cyc == done_at[d]) && !last[d];
      e_dr = (cyc == done_at[d]) && last[d];
      e_we = (cyc == grant_at[d]) && act_we[d];
      ok = ({busy[d], cready[d], dready[d], mwe[d], gnt[d]} ===
            {e_busy, e_cr, e_dr, e_we, last[d]});
      if (e_busy && madr[d] !== act_adr[d]) ok = 1'b0;
      if (e_busy && act_we[d] && mwd[d] !== act_wd[d]) ok = 1'b0;
      if ((e_cr || e_dr) && !act_we[d] && rdata[d] !== exp_rd[d]) ok = 1'b0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand d%0d cyc%0d: got busy,cr,dr,we,gnt=%b adr=%h rd=%h expected %b adr=%h rd=%h",
                 d, cyc, {busy[d], cready[d], dready[d], mwe[d], gnt[d]},
                 madr[d], rdata[d], {e_busy, e_cr, e_dr, e_we, last[d]},
                 act_adr[d], exp_rd[d]);
      end
    end
  endtask

  typedef struct {
    logic        creq, cwe;
    logic [31:0] cadr, cwd;
    logic        dreq, dwe;
    logic [31:0] dadr, dwd;
    logic [4:0]  ctl;
    logic        chk_m;
    logic [31:0] madr, mwd;
    logic        chk_r;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, cw, input logic [31:0] ca, cd,
    input logic dr, dw, input logic [31:0] da, dd,
    input logic [4:0] ctl,
    input logic cm, input logic [31:0] ma, md,
    input logic crd, input logic [31:0] rd);
    vec_t v;
    v.creq = cr; v.cwe = cw; v.cadr = ca; v.cwd = cd;
    v.dreq = dr; v.dwe = dw; v.dadr = da; v.dwd = dd;
    v.ctl = ctl; v.chk_m = cm; v.madr = ma; v.mwd = md;
    v.chk_r = crd; v.rd = rd;
    return v;
  endfunction

  task automatic zero_inputs(input int d);
    creq[d] = 0; cwe[d] = 0; cadr[d] = 0; cwd[d] = 0;
    dreq[d] = 0; dwe[d] = 0; dadr[d] = 0; dwd[d] = 0;
  endtask

  task automatic new_core(input int d);
    creq[d] = 1'b1;
    cwe[d]  = 1'($urandom_range(0, 1));
    cadr[d] = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    cwd[d]  = $urandom;
  endtask

  task automatic new_dbg(input int d);
    dreq[d] = 1'b1;
    dwe[d]  = 1'($urandom_range(0, 1));
    dadr[d] = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    dwd[d]  = $urandom;
  endtask

  vec_t tbl [16];

  initial begin
    int seen, k_rdy, both_cnt, act_cnt;
    int who [4];
    int at [4];
    bit ok;
    logic [31:0] B, D;
    B = 32'hDEAD_BEEF;
    D = 32'h1234_5678;
    // ctl = {busy, core_ready, dbg_ready, gnt_id, mem_we}
    tbl[0]  = mk(1,0,32'h10,0,  0,0,0,0,      5'b00010, 1,0,0,        1,0);
    tbl[1]  = mk(1,0,32'h10,0,  0,0,0,0,      5'b10000, 1,32'h10,0,   0,0);
    tbl[2]  = mk(0,0,0,0,       0,0,0,0,      5'b11000, 1,32'h10,0,   1,B);
    tbl[3]  = mk(0,0,0,0,       1,1,32'h100,D, 5'b00000, 0,0,0,       1,B);
    tbl[4]  = mk(0,0,0,0,       1,1,32'h100,D, 5'b10011, 1,32'h100,D, 0,0);
    tbl[5]  = mk(0,0,0,0,       0,0,0,0,      5'b10110, 1,32'h100,D,  1,B);
    tbl[6]  = mk(1,0,32'h100,0, 0,0,0,0,      5'b00010, 0,0,0,        0,0);
    tbl[7]  = mk(1,0,32'h100,0, 0,0,0,0,      5'b10000, 1,32'h100,0,  0,0);
    tbl[8]  = mk(0,0,0,0,       0,0,0,0,      5'b11000, 0,0,0,        1,D);
    tbl[9]  = mk(1,0,32'h10,0,  1,0,32'h100,0, 5'b00000, 0,0,0,       1,D);
    tbl[10] = mk(1,0,32'h10,0,  1,0,32'h100,0, 5'b10010, 1,32'h100,0, 0,0);
    tbl[11] = mk(1,0,32'h10,0,  1,0,32'h100,0, 5'b10110, 0,0,0,       1,D);
    tbl[12] = mk(1,0,32'h10,0,  1,0,32'h100,0, 5'b00010, 0,0,0,       0,0);
    tbl[13] = mk(1,0,32'h10,0,  0,0,0,0,      5'b10000, 1,32'h10,0,   0,0);
    tbl[14] = mk(0,0,0,0,       0,0,0,0,      5'b11000, 0,0,0,        1,B);
    tbl[15] = mk(0,0,0,0,       0,0,0,0,      5'b00000, 0,0,0,        1,B);

    rst = 2'b11;
    zero_inputs(0);
    zero_inputs(1);
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    rst = 2'b00;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d ctl", i),
          {busy[0], cready[0], dready[0], gnt[0], mwe[0]}, tbl[i].ctl);
      if (tbl[i].chk_m)
        chk($sformatf("vec%0d mem", i), {madr[0], mwd[0]},
            {tbl[i].madr, tbl[i].mwd});
      if (tbl[i].chk_r)
        chk($sformatf("vec%0d rdata", i), rdata[0], tbl[i].rd);
      creq[0] = tbl[i].creq; cwe[0] = tbl[i].cwe;
      cadr[0] = tbl[i].cadr; cwd[0] = tbl[i].cwd;
      dreq[0] = tbl[i].dreq; dwe[0] = tbl[i].dwe;
      dadr[0] = tbl[i].dadr; dwd[0] = tbl[i].dwd;
    end

    // Both requesters held from reset release
    rst[0] = 1'b1;
    zero_inputs(0);
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    creq[0] = 1; cadr[0] = 32'h10;
    dreq[0] = 1; dadr[0] = 32'h100;
    seen = 0;
    both_cnt = 0;
    ok = 1'b1;
    for (int k = 1; k <= 40 && seen < 4; k++) begin
      @(negedge clk);
      if (cready[0] && dready[0]) both_cnt++;
      if (cready[0] || dready[0]) begin
        who[seen] = dready[0] ? 1 : 0;
        at[seen] = k;
        if (gnt[0] !== dready[0]) ok = 1'b0;
        seen++;
      end
    end
    zero_inputs(0);
    chk("rr ready count", 64'(seen), 64'd4);
    if (seen == 4) begin
      chk("rr first latency", 64'(at[0]), 64'(LAT0 + 1));
      chk("rr order", {32'(who[0]), 8'(who[1]), 8'(who[2]), 8'(who[3])},
          {32'd0, 8'd1, 8'd0, 8'd1});
      chk("rr spacing", {16'(at[1] - at[0]), 16'(at[2] - at[1]),
                         16'(at[3] - at[2])},
          {16'(LAT0 + 2), 16'(LAT0 + 2), 16'(LAT0 + 2)});
    end
    chk("rr gnt at ready", 64'(ok), 64'd1);
    chk("rr never both ready", 64'(both_cnt), 64'd0);

    // LATENCY=3 read: latency, stable address, no write
    @(negedge clk);
    creq[1] = 1; cwe[1] = 0; cadr[1] = 32'h20;
    k_rdy = 0;
    ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= LAT1 && (busy[1] !== 1'b1 || madr[1] !== 32'h20 || mwe[1] !== 1'b0))
        ok = 1'b0;
      if (cready[1] && k_rdy == 0) begin
        k_rdy = k;
        chk("l3 read rdata", rdata[1], init_word(1, 8));
        creq[1] = 0;
      end
      if (k == 1) cadr[1] = 32'h3C;
    end
    chk("l3 read latency", 64'(k_rdy), 64'(LAT1 + 1));
    chk("l3 access stable", 64'(ok), 64'd1);

    // LATENCY=3 write interrupted by reset
    zero_inputs(1);
    @(negedge clk);
    creq[1] = 1; cwe[1] = 1; cadr[1] = 32'h24; cwd[1] = 32'h5555_AAAA;
    @(negedge clk);
    chk("l3 wr pulse", {mwe[1], madr[1], mwd[1]}, {1'b1, 32'h24, 32'h5555_AAAA});
    @(negedge clk);
    chk("l3 wr second cycle", {busy[1], mwe[1]}, 2'b10);
    rst[1] = 1'b1;
    #1;
    chk("async reset outs",
        {busy[1], mwe[1], cready[1], dready[1], gnt[1], madr[1], rdata[1]},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0});
    creq[1] = 0;
    @(negedge clk);
    rst[1] = 1'b0;
    dreq[1] = 1; dwe[1] = 0; dadr[1] = 32'h28;
    seen = 0;
    act_cnt = 0;
    for (int k = 1; k <= 10 && seen == 0; k++) begin
      @(negedge clk);
      if (cready[1]) act_cnt++;
      if (dready[1]) seen = k;
    end
    dreq[1] = 0;
    chk("post rst lone dbg", {32'(seen), 32'(act_cnt)}, {32'(LAT1 + 1), 32'd0});

    // Tie straight after reset goes to the core
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    creq[1] = 1; cadr[1] = 32'h2C;
    dreq[1] = 1; dadr[1] = 32'h30;
    seen = 0;
    for (int k = 1; k <= 10 && seen == 0; k++) begin
      @(negedge clk);
      if (cready[1]) seen = 1;
      if (dready[1]) seen = 2;
    end
    zero_inputs(1);
    chk("post rst tie core", 64'(seen), 64'd1);
    repeat (6) @(negedge clk);

    // Core drops req right after the grant
    creq[1] = 1; cadr[1] = 32'h2C;
    @(negedge clk);
    creq[1] = 0;
    seen = 0;
    act_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (seen > 0 && (busy[1] || mwe[1] || cready[1] || dready[1])) act_cnt++;
      if (cready[1]) seen++;
    end
    chk("drop ready count", 64'(seen), 64'd1);
    chk("drop quiet after", 64'(act_cnt), 64'd0);

    // Randomised traffic on both instances against the model
    @(negedge clk);
    rst = 2'b11;
    zero_inputs(0);
    zero_inputs(1);
    sync_ref = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 2'b00;
    sync_ref = 1'b0;
    model_en = 1'b1;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      check_model();
      for (int d = 0; d < 2; d++) begin
        if (creq[d]) begin
          if (cready[d]) begin
            if ($urandom_range(0, 1) == 0) creq[d] = 0;
            else new_core(d);
          end
        end else if ($urandom_range(0, 9) < 4) begin
          new_core(d);
        end
        if (dreq[d]) begin
          if (dready[d]) begin
            if ($urandom_range(0, 1) == 0) dreq[d] = 0;
            else new_dbg(d);
          end
        end else if ($urandom_range(0, 9) < 4) begin
          new_dbg(d);
        end
      end
    end
    model_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
